// File: rtl/load_store_unit_pkg.sv
// Shared constants for the load/store unit.
//   - ALU operation codes that the execute stage hands to the unit
//   - LSU FSM state encoding
//   - response error codes reported on resp_err
package load_store_unit_pkg;

  // ALU operation codes (6 bits). Only the memory ops are recognised by the LSU;
  // any other code is accepted and dropped.
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd24;
  localparam logic [5:0] ALU_LH  = 6'd25;
  localparam logic [5:0] ALU_LW  = 6'd26;
  localparam logic [5:0] ALU_LBU = 6'd27;
  localparam logic [5:0] ALU_LHU = 6'd28;
  localparam logic [5:0] ALU_SB  = 6'd29;
  localparam logic [5:0] ALU_SH  = 6'd30;
  localparam logic [5:0] ALU_SW  = 6'd31;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_MEM  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] LSU_ERR_NONE     = 2'd0;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'd2;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic for the load/store unit.
// Ports:
//   i_alucode    operation code
//   i_addr_lo    low two address bits
//   i_store_data store value (rs2)
//   i_load_data  raw word read from memory
//   o_wstrb      byte lane enables (0 for loads)
//   o_wdata      lane-replicated store data
//   o_load_data  extracted, extended load value
//   o_is_load    code is a load
//   o_is_store   code is a store
//   o_misaligned access not naturally aligned for its size
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [5:0]  i_alucode,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_data,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_load_data[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_load_data[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_wstrb      = 4'b0000;
    o_wdata      = 32'h0;
    o_load_data  = 32'h0;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_misaligned = 1'b0;
    case (i_alucode)
      ALU_LB: begin
        o_is_load   = 1'b1;
        o_load_data = {{24{w_byte[7]}}, w_byte};
      end
      ALU_LBU: begin
        o_is_load   = 1'b1;
        o_load_data = {24'h0, w_byte};
      end
      ALU_LH: begin
        o_is_load    = 1'b1;
        o_misaligned = i_addr_lo[0];
        o_load_data  = {{16{w_half[15]}}, w_half};
      end
      ALU_LHU: begin
        o_is_load    = 1'b1;
        o_misaligned = i_addr_lo[0];
        o_load_data  = {16'h0, w_half};
      end
      ALU_LW: begin
        o_is_load    = 1'b1;
        o_misaligned = (i_addr_lo != 2'b00);
        o_load_data  = i_load_data;
      end
      ALU_SB: begin
        o_is_store = 1'b1;
        o_wstrb    = 4'b0001 << i_addr_lo;
        o_wdata    = {4{i_store_data[7:0]}};
      end
      ALU_SH: begin
        o_is_store   = 1'b1;
        o_misaligned = i_addr_lo[0];
        o_wstrb      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_store_data[15:0]}};
      end
      ALU_SW: begin
        o_is_store   = 1'b1;
        o_misaligned = (i_addr_lo != 2'b00);
        o_wstrb      = 4'b1111;
        o_wdata      = i_store_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and write-back; one transaction in flight.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid/o_req_ready   request handshake from execute
//   i_alucode, i_addr         operation and effective address
//   i_store_data, i_rd_in     store value and load destination
//   o_mem_*                   data-memory request (held until i_mem_ack)
//   i_mem_ack, i_mem_rdata    memory completion pulse and read word
//   o_resp_*                  one-cycle completion to write-back
// TIMEOUT_CYC: cycles to wait for i_mem_ack before aborting (0 = wait forever).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [5:0]  i_alucode,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  input  logic [4:0]  i_rd_in,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_resp_valid,
  output logic        o_resp_we,
  output logic [4:0]  o_resp_rd,
  output logic [31:0] o_resp_data,
  output logic [1:0]  o_resp_err
);

  localparam bit          TimeoutEn   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TimeoutLast = TimeoutEn ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  lsu_state_e  r_state, w_state_d;
  logic [5:0]  r_alucode;
  logic [31:0] r_addr;
  logic [4:0]  r_rd;
  logic        r_store;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt;
  logic [31:0] r_resp_data;
  logic        r_resp_we;
  logic [1:0]  r_resp_err;

  logic        w_req_ready, w_accept, w_timeout;
  logic [5:0]  w_sel_alucode;
  logic [1:0]  w_sel_addr_lo;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_load_data;
  logic        w_is_load, w_is_store, w_misaligned;

  assign w_req_ready = (r_state == LSU_IDLE) && i_rst_n;
  assign o_req_ready = w_req_ready;
  assign w_accept    = i_req_valid && w_req_ready;
  // Ack wins over a timeout that expires in the same cycle.
  assign w_timeout   = TimeoutEn && (r_cnt == TimeoutLast);

  // One aligner serves both phases: in IDLE it decodes the incoming request,
  // afterwards it decodes the registered op to extract the returning load word.
  assign w_sel_alucode = (r_state == LSU_IDLE) ? i_alucode  : r_alucode;
  assign w_sel_addr_lo = (r_state == LSU_IDLE) ? i_addr[1:0] : r_addr[1:0];

  load_store_unit_align u_align (
    .i_alucode    (w_sel_alucode),
    .i_addr_lo    (w_sel_addr_lo),
    .i_store_data (i_store_data),
    .i_load_data  (i_mem_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_misaligned (w_misaligned)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= LSU_IDLE;
    else          r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_accept && (w_is_load || w_is_store)) begin
          w_state_d = w_misaligned ? LSU_RESP : LSU_MEM;
        end
      end
      LSU_MEM:  if (i_mem_ack || w_timeout) w_state_d = LSU_RESP;
      LSU_RESP: w_state_d = LSU_IDLE;
      default:  w_state_d = LSU_IDLE;
    endcase
  end

  // Transaction registers and timeout counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alucode   <= 6'h0;
      r_addr      <= 32'h0;
      r_rd        <= 5'h0;
      r_store     <= 1'b0;
      r_wstrb     <= 4'h0;
      r_wdata     <= 32'h0;
      r_cnt       <= 32'h0;
      r_resp_data <= 32'h0;
      r_resp_we   <= 1'b0;
      r_resp_err  <= LSU_ERR_NONE;
    end else begin
      case (r_state)
        LSU_IDLE: begin
          if (w_accept) begin
            r_alucode   <= i_alucode;
            r_addr      <= i_addr;
            r_rd        <= i_rd_in;
            r_store     <= w_is_store;
            r_wstrb     <= w_wstrb;
            r_wdata     <= w_wdata;
            r_cnt       <= 32'h0;
            r_resp_data <= 32'h0;
            r_resp_we   <= 1'b0;
            r_resp_err  <= w_misaligned ? LSU_ERR_MISALIGN : LSU_ERR_NONE;
          end
        end
        LSU_MEM: begin
          r_cnt <= r_cnt + 32'd1;
          if (i_mem_ack) begin
            r_resp_data <= w_is_load ? w_load_data : 32'h0;
            r_resp_we   <= w_is_load;
          end else if (w_timeout) begin
            r_resp_err  <= LSU_ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: memory port live only in MEM, response only in RESP
  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = 32'h0;
    o_mem_wstrb  = 4'h0;
    o_mem_wdata  = 32'h0;
    o_resp_valid = 1'b0;
    o_resp_we    = 1'b0;
    o_resp_rd    = 5'h0;
    o_resp_data  = 32'h0;
    o_resp_err   = LSU_ERR_NONE;
    case (r_state)
      LSU_MEM: begin
        o_mem_req   = 1'b1;
        o_mem_we    = r_store;
        o_mem_addr  = {r_addr[31:2], 2'b00};
        o_mem_wstrb = r_wstrb;
        o_mem_wdata = r_wdata;
      end
      LSU_RESP: begin
        o_resp_valid = 1'b1;
        o_resp_we    = r_resp_we;
        o_resp_rd    = r_rd;
        o_resp_data  = r_resp_data;
        o_resp_err   = r_resp_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT_CYC = 4).
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [5:0]  alucode;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        resp_valid, resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_alucode    (alucode),
    .i_addr       (addr),
    .i_store_data (store_data),
    .i_rd_in      (rd_in),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wstrb  (mem_wstrb),
    .o_mem_wdata  (mem_wdata),
    .i_mem_ack    (mem_ack),
    .i_mem_rdata  (mem_rdata),
    .o_resp_valid (resp_valid),
    .o_resp_we    (resp_we),
    .o_resp_rd    (resp_rd),
    .o_resp_data  (resp_data),
    .o_resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] data;
    logic [1:0]  err;
    logic        rwe;
  } exp_t;

  typedef struct {
    logic [5:0]  code;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_delay;
    exp_t        e;
  } vec_t;

  typedef struct packed {
    logic        ready_before;
    logic        saw_req;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        we;
    logic        unstable;
    logic        resp_seen;
    logic [31:0] data;
    logic [1:0]  err;
    logic        rwe;
    logic [4:0]  rd;
    logic [7:0]  lat;
    logic [7:0]  mem_n;
    logic        valid_after;
    logic        ready_after;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: derives the expected memory request and response from
  // access size and byte offset using plain arithmetic.
  function automatic exp_t model(input logic [5:0] code, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [31:0] rdata);
    exp_t        e;
    int unsigned size, off, v;
    bit          st, sgn;
    e = '0; size = 4; st = 0; sgn = 0;
    off = a % 4;
    case (code)
      ALU_LB:  begin size = 1; sgn = 1; end
      ALU_LBU: size = 1;
      ALU_LH:  begin size = 2; sgn = 1; end
      ALU_LHU: size = 2;
      ALU_SB:  begin size = 1; st = 1; end
      ALU_SH:  begin size = 2; st = 1; end
      ALU_SW:  begin size = 4; st = 1; end
      default: size = 4;
    endcase
    if ((a % size) != 0) begin
      e.err = LSU_ERR_MISALIGN;
      return e;
    end
    e.req  = 1'b1;
    e.addr = a - off;
    e.we   = st;
    if (st) begin
      if (size == 1) begin
        e.wstrb = 4'(1 << off);
        e.wdata = (sd & 32'hFF) * 32'h01010101;
      end else if (size == 2) begin
        e.wstrb = (off >= 2) ? 4'b1100 : 4'b0011;
        e.wdata = (sd & 32'hFFFF) * 32'h00010001;
      end else begin
        e.wstrb = 4'hF;
        e.wdata = sd;
      end
    end else begin
      e.rwe = 1'b1;
      if (size == 1) begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (sgn && v >= 128) v = v - 256;
      end else if (size == 2) begin
        v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        if (sgn && v >= 32768) v = v - 65536;
      end else begin
        v = rdata;
      end
      e.data = v;
    end
    return e;
  endfunction

  // Issue one request and watch the ports. ack_delay = index of the MEM cycle
  // in which mem_ack is pulsed (-1: never).
  task automatic do_txn(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [31:0] rdata, input int ack_delay,
                        output obs_t o);
    int mem_n;
    bit done;
    o = '0;
    mem_n = 0;
    done = 0;
    req_valid = 1'b1; alucode = code; addr = a; store_data = sd; rd_in = rd;
    o.ready_before = req_ready;
    step();
    // Scramble request inputs to show they were registered at accept.
    req_valid = 1'b0; alucode = ALU_ADD; addr = $urandom; store_data = $urandom;
    rd_in = 5'($urandom);
    for (int cyc = 1; cyc <= 12 && !done; cyc++) begin
      if (mem_req) begin
        if (mem_n == 0) begin
          o.saw_req = 1'b1; o.addr = mem_addr; o.wstrb = mem_wstrb;
          o.wdata = mem_wdata; o.we = mem_we;
        end else if (mem_addr !== o.addr || mem_wstrb !== o.wstrb ||
                     mem_wdata !== o.wdata || mem_we !== o.we) begin
          o.unstable = 1'b1;
        end
        if (mem_n == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
        mem_n++;
      end
      if (resp_valid) begin
        o.resp_seen = 1'b1; o.data = resp_data; o.err = resp_err;
        o.rwe = resp_we; o.rd = resp_rd; o.lat = 8'(cyc);
        done = 1;
      end
      step();
      mem_ack = 1'b0;
    end
    o.mem_n = 8'(mem_n);
    o.valid_after = resp_valid;
    o.ready_after = req_ready;
  endtask

  task automatic check_txn(input string tag, input exp_t e, input logic [4:0] rd,
                           input int exp_lat, input obs_t o);
    check({tag, " ready"}, 32'(o.ready_before), 32'd1);
    check({tag, " mem_req"}, 32'(o.saw_req), 32'(e.req));
    if (e.req) begin
      check({tag, " mem_addr"}, o.addr, e.addr);
      check({tag, " wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
      check({tag, " mem_we"}, 32'(o.we), 32'(e.we));
      check({tag, " stable"}, 32'(o.unstable), 32'd0);
      if (e.we) check({tag, " wdata"}, o.wdata, e.wdata);
    end
    check({tag, " resp_seen"}, 32'(o.resp_seen), 32'd1);
    check({tag, " resp_data"}, o.data, e.data);
    check({tag, " resp_err"}, 32'(o.err), 32'(e.err));
    check({tag, " resp_we"}, 32'(o.rwe), 32'(e.rwe));
    if (e.rwe) check({tag, " resp_rd"}, 32'(o.rd), 32'(rd));
    check({tag, " latency"}, 32'(o.lat), 32'(exp_lat));
    check({tag, " pulse"}, 32'(o.valid_after), 32'd0);
    check({tag, " ready_after"}, 32'(o.ready_after), 32'd1);
  endtask

  function automatic vec_t mkv(input logic [5:0] code, input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rdata, input int ad, input logic req,
                               input logic [31:0] ma, input logic [3:0] st, input logic [31:0] wd,
                               input logic we, input logic [31:0] d, input logic [1:0] err,
                               input logic rwe);
    vec_t v;
    v.code = code; v.addr = a; v.sd = sd; v.rdata = rdata; v.ack_delay = ad;
    v.e.req = req; v.e.addr = ma; v.e.wstrb = st; v.e.wdata = wd; v.e.we = we;
    v.e.data = d; v.e.err = err; v.e.rwe = rwe;
    return v;
  endfunction

  logic [5:0] mem_codes [8];
  vec_t       vecs [11];

  initial begin
    obs_t       o;
    exp_t       e;
    logic [5:0] code;
    logic [31:0] a, sd, rdata;
    logic [4:0] rd;
    int         ad;

    mem_codes = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};
    //                 code     addr      sd            rdata         ack req maddr   strb  wdata         we data          err rwe
    vecs[0]  = mkv(ALU_SW,  32'h100,  32'hDEADBEEF, 32'h0,        3, 1, 32'h100,  4'hF, 32'hDEADBEEF, 1, 32'h0,        0, 0);
    vecs[1]  = mkv(ALU_LB,  32'h103,  32'h0,        32'h80FF0000, 1, 1, 32'h100,  4'h0, 32'h0,        0, 32'hFFFFFF80, 0, 1);
    vecs[2]  = mkv(ALU_LBU, 32'h103,  32'h0,        32'h80FF0000, 0, 1, 32'h100,  4'h0, 32'h0,        0, 32'h00000080, 0, 1);
    vecs[3]  = mkv(ALU_SH,  32'h22,   32'h1234ABCD, 32'h0,        0, 1, 32'h20,   4'hC, 32'hABCDABCD, 1, 32'h0,        0, 0);
    vecs[4]  = mkv(ALU_LW,  32'h102,  32'h0,        32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0, 32'h0,        1, 0);
    vecs[5]  = mkv(ALU_LH,  32'h42,   32'h0,        32'h80011234, 2, 1, 32'h40,   4'h0, 32'h0,        0, 32'hFFFF8001, 0, 1);
    vecs[6]  = mkv(ALU_LHU, 32'h40,   32'h0,        32'h8001F234, 1, 1, 32'h40,   4'h0, 32'h0,        0, 32'h0000F234, 0, 1);
    vecs[7]  = mkv(ALU_SB,  32'h1002, 32'h000000A5, 32'h0,        2, 1, 32'h1000, 4'h4, 32'hA5A5A5A5, 1, 32'h0,        0, 0);
    vecs[8]  = mkv(ALU_LW,  32'h204,  32'h0,        32'hCAFEF00D, 0, 1, 32'h204,  4'h0, 32'h0,        0, 32'hCAFEF00D, 0, 1);
    vecs[9]  = mkv(ALU_SH,  32'h31,   32'h55AA55AA, 32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0, 32'h0,        1, 0);
    vecs[10] = mkv(ALU_LHU, 32'h43,   32'h0,        32'h0,        0, 0, 32'h0,    4'h0, 32'h0,        0, 32'h0,        1, 0);

    rst_n = 1'b0; req_valid = 1'b0; alucode = ALU_ADD; addr = '0; store_data = '0;
    rd_in = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset state
    repeat (3) step();
    check("reset req_ready", 32'(req_ready), 32'd0);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset resp_data", resp_data, 32'h0);
    rst_n = 1'b1;
    step();
    check("post-reset req_ready", 32'(req_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].code, vecs[i].addr, vecs[i].sd, 5'(i + 3), vecs[i].rdata,
             vecs[i].ack_delay, o);
      check_txn($sformatf("vec%0d", i), vecs[i].e, 5'(i + 3),
                vecs[i].e.req ? vecs[i].ack_delay + 2 : 1, o);
    end

    // Non-memory op is dropped without a response
    do_txn(ALU_ADD, 32'h100, 32'h1, 5'd1, 32'h0, 0, o);
    check("nonmem mem_req", 32'(o.saw_req), 32'd0);
    check("nonmem resp", 32'(o.resp_seen), 32'd0);
    check("nonmem ready", 32'(o.ready_after), 32'd1);

    // Ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ack = 1'b0;
    check("idle ack resp_valid", 32'(resp_valid), 32'd0);
    check("idle ack mem_req", 32'(mem_req), 32'd0);

    // Timeout: LH with no ack holds mem_req for 4 cycles
    do_txn(ALU_LH, 32'h40, 32'h0, 5'd9, 32'h0, -1, o);
    check("timeout mem cycles", 32'(o.mem_n), 32'd4);
    check("timeout mem_addr", o.addr, 32'h40);
    check("timeout resp_seen", 32'(o.resp_seen), 32'd1);
    check("timeout err", 32'(o.err), 32'(LSU_ERR_TIMEOUT));
    check("timeout data", o.data, 32'h0);
    check("timeout resp_we", 32'(o.rwe), 32'd0);
    check("timeout latency", 32'(o.lat), 32'd5);

    // Reset in the middle of a LW memory phase
    req_valid = 1'b1; alucode = ALU_LW; addr = 32'h80; rd_in = 5'd7;
    step();
    req_valid = 1'b0; alucode = ALU_ADD;
    check("rst-mid mem_req", 32'(mem_req), 32'd1);
    step();
    rst_n = 1'b0;
    step();
    check("rst-mid mem_req dropped", 32'(mem_req), 32'd0);
    check("rst-mid resp_valid", 32'(resp_valid), 32'd0);
    check("rst-mid req_ready low", 32'(req_ready), 32'd0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    step();
    mem_ack = 1'b0;
    check("late ack resp_valid", 32'(resp_valid), 32'd0);
    check("late ack mem_req", 32'(mem_req), 32'd0);
    check("late ack ready", 32'(req_ready), 32'd1);
    step();
    check("late ack resp_valid 2", 32'(resp_valid), 32'd0);

    // Back-to-back after reset release
    do_txn(ALU_LW, 32'h84, 32'h0, 5'd11, 32'h11223344, 1, o);
    check_txn("b2b0", model(ALU_LW, 32'h84, 32'h0, 32'h11223344), 5'd11, 3, o);
    do_txn(ALU_SB, 32'h85, 32'h5A, 5'd12, 32'h0, 0, o);
    check_txn("b2b1", model(ALU_SB, 32'h85, 32'h5A, 32'h0), 5'd12, 2, o);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      code  = mem_codes[$urandom_range(0, 7)];
      a     = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      sd    = $urandom;
      rdata = $urandom;
      rd    = 5'($urandom);
      ad    = int'($urandom_range(0, 3));
      e     = model(code, a, sd, rdata);
      do_txn(code, a, sd, rd, rdata, ad, o);
      check_txn($sformatf("rand%0d", i), e, rd, e.req ? ad + 2 : 1, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
